// File: rtl/osc_freq_monitor.sv
// Multi-channel oscillator frequency monitor: counts synchronised toggle edges over a fixed
// gate window and checks each count against per-channel runtime limits.
module osc_freq_monitor #(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned GATE_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    EN,
    input  logic                    CLEAR,
    input  logic [NUM_CH-1:0]       TOGGLE_IN,
    input  logic [NUM_CH*CNT_W-1:0] LIMIT_LO,
    input  logic [NUM_CH*CNT_W-1:0] LIMIT_HI,
    output logic [NUM_CH*CNT_W-1:0] COUNT_OUT,
    output logic                    VALID,
    output logic [NUM_CH-1:0]       FAIL,
    output logic                    OK,
    output logic                    BUSY
);

    localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        StIdle,
        StMeasure,
        StLatch
    } state_e;

    state_e state_q, state_d;

    logic [GATE_W-1:0]                  gate_q, gate_d;
    logic [NUM_CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0]       count_out_q, count_out_d;
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
    logic [NUM_CH-1:0]                  hist_q, hist_d;
    logic [NUM_CH-1:0]                  fail_q, fail_d;
    logic                               valid_q, valid_d;
    logic                               ok_q, ok_d;
    logic                               busy_q, busy_d;

    logic [NUM_CH-1:0][CNT_W-1:0]       lim_lo, lim_hi;
    logic [NUM_CH-1:0]                  edge_det;
    logic [NUM_CH-1:0]                  pass;

    assign lim_lo = LIMIT_LO;
    assign lim_hi = LIMIT_HI;

    // Edge = output of the last synchroniser stage differing from its history copy.
    assign edge_det = sync_q[SYNC_STAGES-1] ^ hist_q;

    always_comb begin
        sync_d[0] = TOGGLE_IN;
        for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Inclusive unsigned window; LO > HI can never pass.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pass[i] = (cnt_q[i] >= lim_lo[i]) && (cnt_q[i] <= lim_hi[i]);
        end
    end

    always_comb begin
        state_d     = state_q;
        gate_d      = gate_q;
        cnt_d       = cnt_q;
        count_out_d = count_out_q;
        ok_d        = ok_q;
        valid_d     = 1'b0;
        fail_d      = CLEAR ? '0 : fail_q;

        unique case (state_q)
            StIdle: begin
                if (EN) begin
                    state_d = StMeasure;
                    gate_d  = '0;
                    cnt_d   = '0;
                end
            end
            StMeasure: begin
                if (!EN) begin
                    state_d = StIdle;
                end else begin
                    gate_d = gate_q + GATE_W'(1);
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (edge_det[i] && (cnt_q[i] != CNT_MAX)) begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    if (gate_q == GATE_LAST) begin
                        state_d = StLatch;
                    end
                end
            end
            StLatch: begin
                count_out_d = cnt_q;
                ok_d        = &pass;
                fail_d      = fail_d | ~pass;
                valid_d     = 1'b1;
                if (EN) begin
                    state_d = StMeasure;
                    gate_d  = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            gate_q      <= '0;
            cnt_q       <= '0;
            count_out_q <= '0;
            sync_q      <= '0;
            hist_q      <= '0;
            fail_q      <= '0;
            valid_q     <= 1'b0;
            ok_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gate_q      <= gate_d;
            cnt_q       <= cnt_d;
            count_out_q <= count_out_d;
            sync_q      <= sync_d;
            hist_q      <= hist_d;
            fail_q      <= fail_d;
            valid_q     <= valid_d;
            ok_q        <= ok_d;
            busy_q      <= busy_d;
        end
    end

    assign COUNT_OUT = count_out_q;
    assign VALID     = valid_q;
    assign FAIL      = fail_q;
    assign OK        = ok_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_osc_freq_monitor.sv
// Scoreboard bench for osc_freq_monitor: expected window results are queued when a window is
// started and checked when VALID pulses.
module tb_osc_freq_monitor;

    logic        clk;
    logic        reset;
    logic        en;
    logic        clear;
    logic [3:0]  tg;
    logic [2:0][15:0] lim_lo, lim_hi;
    logic [47:0] count_out;
    logic        valid;
    logic [2:0]  fail;
    logic        ok;
    logic        busy;

    logic [11:0] sat_count;
    logic        sat_valid;
    logic [2:0]  sat_fail;
    logic        sat_ok;
    logic        sat_busy;

    int total = 0;
    int bad   = 0;
    int per[4] = '{4, 0, 5, 3};
    int ph[4]  = '{0, 0, 0, 0};

    typedef struct {
        logic [15:0] c0;
        logic [15:0] c1;
        logic [15:0] c2;
        logic        ok;
        logic [2:0]  fail;
    } exp_t;

    exp_t exp_q[$];

    osc_freq_monitor #(
        .NUM_CH(3), .CNT_W(16), .GATE_CYCLES(100), .SYNC_STAGES(2)
    ) u_dut (
        .CLK(clk), .RESET(reset), .EN(en), .CLEAR(clear), .TOGGLE_IN(tg[2:0]),
        .LIMIT_LO(lim_lo), .LIMIT_HI(lim_hi), .COUNT_OUT(count_out), .VALID(valid),
        .FAIL(fail), .OK(ok), .BUSY(busy)
    );

    // Narrow-counter instance for saturation; its ch2 sees a period-3 toggle.
    osc_freq_monitor #(
        .NUM_CH(3), .CNT_W(4), .GATE_CYCLES(100), .SYNC_STAGES(2)
    ) u_dut_sat (
        .CLK(clk), .RESET(reset), .EN(en), .CLEAR(clear), .TOGGLE_IN({tg[3], tg[1], tg[0]}),
        .LIMIT_LO(12'h000), .LIMIT_HI(12'hfff), .COUNT_OUT(sat_count), .VALID(sat_valid),
        .FAIL(sat_fail), .OK(sat_ok), .BUSY(sat_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tg = '0;
        forever begin
            @(posedge clk);
            #3;
            for (int c = 0; c < 4; c++) begin
                if (per[c] != 0) begin
                    ph[c] = ph[c] + 1;
                    if (ph[c] >= per[c]) begin
                        ph[c] = 0;
                        tg[c] = ~tg[c];
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                            input logic o, input logic [2:0] f);
        exp_t e;
        e.c0 = c0; e.c1 = c1; e.c2 = c2; e.ok = o; e.fail = f;
        exp_q.push_back(e);
    endtask

    task automatic score();
        exp_t e;
        check_eq("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("cnt0", 32'(count_out[15:0]), 32'(e.c0));
            check_eq("cnt1", 32'(count_out[31:16]), 32'(e.c1));
            check_eq("cnt2", 32'(count_out[47:32]), 32'(e.c2));
            check_eq("ok", 32'(ok), 32'(e.ok));
            check_eq("fail", 32'(fail), 32'(e.fail));
        end
    endtask

    // Steps n cycles, ending on a negedge; any VALID seen is scored.
    task automatic step_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid === 1'b1) score();
        end
    endtask

    task automatic wait_valid(output int n);
        logic seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 400) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (valid === 1'b1) begin
                seen = 1'b1;
                score();
                @(posedge clk);
                @(negedge clk);
                check_eq("valid_one_cycle", 32'(valid), 32'd0);
            end
        end
        check_eq("valid_seen", 32'(seen), 32'd1);
    endtask

    int n;

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        clear = 1'b0;
        lim_lo[0] = 16'd20; lim_hi[0] = 16'd30;
        lim_lo[1] = 16'd20; lim_hi[1] = 16'd30;
        lim_lo[2] = 16'd0;  lim_hi[2] = 16'd100;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step_cycles(2);
        check_eq("rst_count", 32'(count_out != 48'd0), 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_fail", 32'(fail), 32'd0);
        check_eq("rst_ok", 32'(ok), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);

        // W1/W2: ch1 dead -> fails low limit; back-to-back period 101.
        push_exp(16'd25, 16'd0, 16'd20, 1'b0, 3'b010);
        en = 1'b1;
        wait_valid(n);
        check_eq("w1_latency", 32'(n), 32'd102);
        check_eq("sat_cnt0", 32'(sat_count[3:0]), 32'd15);
        check_eq("sat_cnt2", 32'(sat_count[11:8]), 32'd15);
        check_eq("sat_valid_prev", 32'(sat_valid), 32'd0);
        push_exp(16'd25, 16'd0, 16'd20, 1'b0, 3'b010);
        wait_valid(n);
        check_eq("w2_period", 32'(n), 32'd100);

        // W3: ch1 alive, sticky FAIL[1] remains.
        en = 1'b0;
        per[1] = 4;
        step_cycles(30);
        push_exp(16'd25, 16'd25, 16'd20, 1'b1, 3'b010);
        en = 1'b1;
        wait_valid(n);
        check_eq("w3_latency", 32'(n), 32'd102);

        // Abort at gate 50 of the following window (one cycle already consumed above).
        step_cycles(49);
        en = 1'b0;
        step_cycles(1);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_cnt0", 32'(count_out[15:0]), 32'd25);
        check_eq("abort_cnt1", 32'(count_out[31:16]), 32'd25);
        check_eq("abort_ok", 32'(ok), 32'd1);
        step_cycles(150);
        push_exp(16'd25, 16'd25, 16'd20, 1'b1, 3'b010);
        en = 1'b1;
        wait_valid(n);
        check_eq("reraise_latency", 32'(n), 32'd102);

        // Reset at gate 60 of the next window.
        step_cycles(59);
        check_eq("pre_rst_fail", 32'(fail), 32'b010);
        check_eq("pre_rst_ok", 32'(ok), 32'd1);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        en    = 1'b0;
        step_cycles(1);
        reset = 1'b0;
        check_eq("mid_rst_count", 32'(count_out != 48'd0), 32'd0);
        check_eq("mid_rst_valid", 32'(valid), 32'd0);
        check_eq("mid_rst_fail", 32'(fail), 32'd0);
        check_eq("mid_rst_ok", 32'(ok), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        step_cycles(150);
        check_eq("post_rst_busy", 32'(busy), 32'd0);

        // W5: ch0 slowed to 5 edges, ch1 dead -> FAIL=011.
        per[0] = 20;
        per[1] = 0;
        step_cycles(60);
        push_exp(16'd5, 16'd0, 16'd20, 1'b0, 3'b011);
        en = 1'b1;
        wait_valid(n);
        check_eq("w5_latency", 32'(n), 32'd102);

        // W6: ch1 limit relaxed mid-window, CLEAR coincides with LATCH -> FAIL=001.
        lim_lo[1] = 16'd0;
        push_exp(16'd5, 16'd0, 16'd20, 1'b0, 3'b001);
        step_cycles(99);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        check_eq("w6_valid", 32'(valid), 32'd1);
        if (valid === 1'b1) score();

        en = 1'b0;
        step_cycles(5);
        clear = 1'b1;
        step_cycles(1);
        clear = 1'b0;
        check_eq("clear_fail", 32'(fail), 32'd0);

        // W8: inclusive bounds on ch0/ch1, inverted limits on ch2.
        lim_lo[0] = 16'd5;  lim_hi[0] = 16'd5;
        lim_lo[1] = 16'd0;  lim_hi[1] = 16'd0;
        lim_lo[2] = 16'd20; lim_hi[2] = 16'd19;
        push_exp(16'd5, 16'd0, 16'd20, 1'b0, 3'b100);
        en = 1'b1;
        wait_valid(n);
        check_eq("w8_latency", 32'(n), 32'd102);
        en = 1'b0;
        step_cycles(10);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/osc_freq_monitor.md
Name: osc_freq_monitor

Overview:
- Multi-channel oscillator frequency and health monitor for the fabric oscillator subsystem. Runs on the fabric clock (RC oscillator 50 MHz via global buffer).
- Each channel gets a toggle signal. That toggle is a divide-by-2 flop, or a prescaled flop, clocked in the monitored oscillator's own domain: RC 1 MHz, XTL, CCC outputs.
- Counts toggle edges over a fixed gate window. Reports per-window counts, checks each count against runtime limits, and raises sticky failure flags.
- Supervisor logic reads the flags to detect a dead or off-frequency oscillator.

Parameters:
- NUM_CH, 3, number of monitored channels (1..8)
- CNT_W, 16, width of each edge counter and limit
- GATE_CYCLES, 50000, CLK cycles per measurement window (≥4; 1 ms at 50 MHz)
- SYNC_STAGES, 2, synchroniser flops per toggle input (≥2)

Ports:
- CLK  in  1  fabric clock
- RESET  in  1  synchronous, active-high reset
- EN  in  1  level; 1 = run back-to-back windows
- CLEAR  in  1  one-cycle pulse; clears sticky FAIL
- TOGGLE_IN  in  NUM_CH  asynchronous toggle per channel
- LIMIT_LO  in  NUM_CH*CNT_W  per-channel minimum count; ch i at [i*CNT_W +: CNT_W]
- LIMIT_HI  in  NUM_CH*CNT_W  per-channel maximum count; same packing
- COUNT_OUT  out  NUM_CH*CNT_W  last completed window counts; same packing
- VALID  out  1  one-cycle pulse; COUNT_OUT/OK updated
- FAIL  out  NUM_CH  sticky per-channel out-of-range flag
- OK  out  1  last completed window had all channels in range
- BUSY  out  1  high in MEASURE or LATCH

Behaviour:
- Reset values: COUNT_OUT=0, VALID=0, FAIL=0, OK=0, BUSY=0, state IDLE, all internal counters and synchroniser flops 0.
- Input synchronisation:
  - Each TOGGLE_IN passes through SYNC_STAGES flops plus one history flop.
  - Edge detect = XOR of the last two flops. Both edges count.
  - Edge rate must be ≤ CLK/3; faster inputs are out of contract.
- FSM IDLE:
  - BUSY=0.
  - EN=1 → MEASURE next cycle. On entry, gate counter and all edge counters clear.
- FSM MEASURE:
  - Gate counter increments 0..GATE_CYCLES-1.
  - Each channel counter increments on a detected edge and saturates at 2^CNT_W-1 (no wrap).
  - At gate count GATE_CYCLES-1 → LATCH.
  - EN=0 in any MEASURE cycle → IDLE next cycle (abort). No VALID, and COUNT_OUT/OK/FAIL stay unchanged.
- FSM LATCH (one cycle):
  - Register COUNT_OUT from the counters.
  - Per-channel compare: pass iff LIMIT_LO ≤ count ≤ LIMIT_HI (unsigned, inclusive).
  - OK = AND of all pass bits. FAIL[i] set where the channel fails.
  - VALID=1 in the cycle after LATCH, for exactly one cycle.
  - Next state: EN=1 → MEASURE (counters clear), else IDLE.
  - Edges detected during the LATCH cycle are dropped: one-cycle dead time.
- Timing:
  - EN sampled high in IDLE at edge t → MEASURE spans t+1..t+GATE_CYCLES, LATCH at t+GATE_CYCLES+1, VALID high at t+GATE_CYCLES+2.
  - With EN held high, the window period is GATE_CYCLES+1 cycles.
- FAIL/CLEAR:
  - FAIL[i] holds until CLEAR.
  - CLEAR in the same cycle as a LATCH that fails channel i: FAIL[i] stays 1 (set wins). Other channels clear.
- Limits are sampled only in the LATCH cycle. Changes at other times have no effect on the current window.
- LIMIT_LO > LIMIT_HI on a channel: that channel always fails.
- RESET in any state, including mid-window, returns everything to reset values next cycle. It also clears sticky FAIL.

Test Plan:
- NUM_CH=3, GATE_CYCLES=100, ch0 toggles every 4 CLK (steady before EN), LIMIT ch0=20..30, EN=1 → VALID at EN+102 cycles, COUNT_OUT ch0=25, FAIL[0]=0; next VALID 101 cycles later, also 25.
- Ch1 held at 0, LIMIT_LO ch1=20 → COUNT ch1=0, FAIL[1]=1, OK=0. Ch1 then toggles every 4 → next window OK=1 and FAIL[1] still 1. CLEAR pulse → FAIL[1]=0.
- CNT_W=4, ch2 toggles every 3 CLK, GATE_CYCLES=100 → COUNT ch2=15 (saturated, not 33 mod 16=1).
- EN dropped at gate count 50 → no VALID, BUSY=0 next cycle, COUNT_OUT unchanged. EN re-raised → full 100-cycle window, VALID at EN+102.
- RESET pulsed at gate count 60 with FAIL=3'b010, OK=1 → next cycle all outputs 0, state IDLE; no VALID until EN is re-sampled.
- CLEAR asserted in the LATCH cycle where ch0 count=5 < LIMIT_LO=20 and FAIL=3'b011 → FAIL=3'b001 after the cycle.
